// File: rtl/riscv_board_pkg.sv
// Shared types, sizes and the seven-segment decoder for the board top.
package riscv_board_pkg;

  localparam int IN_W   = 18;
  localparam int DIGITS = 8;
  localparam int GPIO_W = 4 * DIGITS;
  localparam int CNT_W  = 5;

  // All segments off on an active-low display.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Active-low segments ordered {g,f,e,d,c,b,a}.
  // A..F are decoded only so that a corrupted nibble still shows something.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/riscv_board_bcd_engine.sv
// Double-dabble binary-to-BCD converter running continuously:
// LOAD -> SHIFT x IN_W -> DONE -> LOAD, 20 cycles per conversion.
// gpio_out only changes in DONE, so a reset mid-conversion never leaks
// a partial result. The FSM state register is named `state` for probing.
module bcd_engine
  import riscv_board_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   bin_in,
  output logic [GPIO_W-1:0] gpio_out
);

  conv_state_t       state, state_next;
  logic [IN_W-1:0]   shreg, shreg_next;
  logic [GPIO_W-1:0] scratch, scratch_next;
  logic [GPIO_W-1:0] adj;
  logic [CNT_W-1:0]  count, count_next;
  logic [GPIO_W-1:0] gpio_next;

  // Add-3 correction: every scratch digit >= 5 gets 3 added before the shift.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state and datapath updates for the conversion FSM.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    scratch_next = scratch;
    count_next   = count;
    gpio_next    = gpio_out;
    case (state)
      LOAD: begin
        shreg_next   = bin_in;
        scratch_next = '0;
        count_next   = '0;
        state_next   = SHIFT;
      end
      SHIFT: begin
        scratch_next = {adj[GPIO_W-2:0], shreg[IN_W-1]};
        shreg_next   = {shreg[IN_W-2:0], 1'b0};
        count_next   = count + 1'b1;
        if (count == CNT_W'(IN_W - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        gpio_next  = scratch;
        state_next = LOAD;
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= LOAD;
      shreg    <= '0;
      scratch  <= '0;
      count    <= '0;
      gpio_out <= '0;
    end else begin
      state    <= state_next;
      shreg    <= shreg_next;
      scratch  <= scratch_next;
      count    <= count_next;
      gpio_out <= gpio_next;
    end
  end

endmodule

// File: rtl/riscv_board_top.sv
// Board top: SW is converted to 8 BCD digits by `mycpu` and each digit is
// shown on an active-low seven-segment display (HEX0 = least significant).
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading-zero displays
// HEX7..HEX1; HEX0 always shows its digit.
module riscv_board_top
  import riscv_board_pkg::*;
(
  input  logic            CLOCK_50,
  input  logic            CLOCK2_50,
  input  logic            CLOCK3_50,
  input  logic [3:0]      KEY,
  input  logic [IN_W-1:0] SW,
  output logic [6:0]      HEX0,
  output logic [6:0]      HEX1,
  output logic [6:0]      HEX2,
  output logic [6:0]      HEX3,
  output logic [6:0]      HEX4,
  output logic [6:0]      HEX5,
  output logic [6:0]      HEX6,
  output logic [6:0]      HEX7
);

  logic [GPIO_W-1:0] gpio_out;
  logic [6:0]        hex_seg [DIGITS];

  // Spare board inputs, intentionally not used by this design.
  wire unused_inputs = &{1'b0, KEY[3:1], CLOCK2_50, CLOCK3_50};

  bcd_engine mycpu (
    .clk      (CLOCK_50),
    .rst_n    (KEY[0]),
    .bin_in   (SW),
    .gpio_out (gpio_out)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic lead_zero;

  // Decode every digit, then blank displays above the most significant non-zero digit.
  always_comb begin
    lead_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      hex_seg[i] = seg7(gpio_out[4*i +: 4]);
    end
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead_zero = lead_zero & (gpio_out[4*i +: 4] == 4'd0);
      if (lead_zero) begin
        hex_seg[i] = SEG_BLANK;
      end
    end
  end
`else
  // Decode every digit; leading zeros stay visible.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      hex_seg[i] = seg7(gpio_out[4*i +: 4]);
    end
  end
`endif

  assign HEX0 = hex_seg[0];
  assign HEX1 = hex_seg[1];
  assign HEX2 = hex_seg[2];
  assign HEX3 = hex_seg[3];
  assign HEX4 = hex_seg[4];
  assign HEX5 = hex_seg[5];
  assign HEX6 = hex_seg[6];
  assign HEX7 = hex_seg[7];

endmodule

// File: tb/tb_riscv_board_top.sv
// Bench for riscv_board_top: directed SW/reset vectors with hand-computed
// BCD results; expected {gpio_out, HEX7..HEX0} go into a queue and a
// monitor process pops and compares them against the DUT.
module tb_riscv_board_top;

  localparam int W = 32 + 56;

  // clock/reset block
  logic        CLOCK_50  = 1'b0;
  logic        CLOCK2_50 = 1'b0;
  logic        CLOCK3_50 = 1'b0;
  logic [3:0]  KEY       = 4'b1110;
  logic [17:0] SW        = 18'd0;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

  initial forever #10 CLOCK_50  = ~CLOCK_50;
  initial forever #10 CLOCK2_50 = ~CLOCK2_50;
  initial forever #10 CLOCK3_50 = ~CLOCK3_50;

  riscv_board_top dut (
    .CLOCK_50  (CLOCK_50),
    .CLOCK2_50 (CLOCK2_50),
    .CLOCK3_50 (CLOCK3_50),
    .KEY       (KEY),
    .SW        (SW),
    .HEX0      (HEX0),
    .HEX1      (HEX1),
    .HEX2      (HEX2),
    .HEX3      (HEX3),
    .HEX4      (HEX4),
    .HEX5      (HEX5),
    .HEX6      (HEX6),
    .HEX7      (HEX7)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  event         chk_ev;

  // hand table of active-low {g,f,e,d,c,b,a} digit patterns
  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  // expected HEX7..HEX0 for a given BCD word
  function automatic logic [55:0] hex_ref(input logic [31:0] g);
    logic [55:0] h;
    logic        lz;
    lz = 1'b1;
    for (int i = 0; i < 8; i++) h[7*i +: 7] = seg_ref(g[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 7; i >= 1; i--) begin
      lz = lz & (g[4*i +: 4] == 4'd0);
      if (lz) h[7*i +: 7] = 7'h7F;
    end
`endif
    return h;
  endfunction

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic apply_reset(input int n);
    @(negedge CLOCK_50);
    KEY[0] = 1'b0;
    wait_cycles(n);
    KEY[0] = 1'b1;
  endtask

  task automatic expect_val(input logic [31:0] g, input string name);
    exp_q.push_back({g, hex_ref(g)});
    name_q.push_back(name);
    -> chk_ev;
    #1;
  endtask

  task automatic convert(input logic [17:0] sw, input logic [31:0] g, input string name);
    SW = sw;
    apply_reset(2);
    wait_cycles(100);
    expect_val(g, name);
  endtask

  // monitor: pops every pending expectation and compares with the DUT
  initial begin
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        logic [W-1:0] e;
        logic [55:0]  act_h;
        logic [31:0]  act_g;
        string        nm;
        e     = exp_q.pop_front();
        nm    = name_q.pop_front();
        act_g = dut.mycpu.gpio_out;
        act_h = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
        n_checks++;
        if (act_g !== e[W-1 -: 32]) begin
          n_fail++;
          $display("FAIL %s gpio_out: got %h expected %h", nm, act_g, e[W-1 -: 32]);
        end
        n_checks++;
        if (act_h !== e[55:0]) begin
          n_fail++;
          $display("FAIL %s hex: got %h expected %h", nm, act_h, e[55:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    KEY = 4'b1110;
    SW  = 18'd42;
    wait_cycles(2);
    expect_val(32'h0, "reset_state");
    KEY[0] = 1'b1;
    wait_cycles(18);
    expect_val(32'h0, "before_first_done");
    wait_cycles(82);
    expect_val(32'h00000042, "sw_42");

    convert(18'd123,    32'h00000123, "sw_123");
    convert(18'd999,    32'h00000999, "sw_999");
    convert(18'd262143, 32'h00262143, "sw_max");
    convert(18'd0,      32'h00000000, "sw_zero");
    convert(18'd100000, 32'h00100000, "sw_100000");
    convert(18'd9876,   32'h00009876, "sw_9876");

    // reset held low clears a previous non-zero result
    @(negedge CLOCK_50);
    KEY[0] = 1'b0;
    wait_cycles(3);
    expect_val(32'h0, "reset_hold");

    // reset at cycle 10 of a conversion aborts it
    SW = 18'd555;
    KEY[0] = 1'b1;
    wait_cycles(10);
    KEY[0] = 1'b0;
    wait_cycles(2);
    expect_val(32'h0, "abort_in_reset");
    KEY[0] = 1'b1;
    wait_cycles(15);
    expect_val(32'h0, "abort_no_partial");
    wait_cycles(10);
    expect_val(32'h00000555, "abort_recover");

    // SW change during SHIFT is picked up only at the next LOAD
    SW = 18'd300;
    apply_reset(2);
    wait_cycles(5);
    SW = 18'd400;
    wait_cycles(20);
    expect_val(32'h00000300, "sw_ignored_in_shift");
    wait_cycles(30);
    expect_val(32'h00000400, "sw_next_load");

    // SW change without reset is reflected within 40 cycles
    convert(18'd42, 32'h00000042, "sw_42_again");
    SW = 18'd7;
    for (int k = 0; k < 40 && dut.mycpu.gpio_out !== 32'h7; k++) @(negedge CLOCK_50);
    expect_val(32'h00000007, "sw_7_within_40");

    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
